// File: rtl/rede_float_pkg.sv
// Shared types and widths for the rede_float neuron core.
// Sequencer states, datapath widths and the output saturation window.
package rede_float_pkg;

    localparam int IN_W   = 19;
    localparam int W_W    = 12;
    localparam int ACC_W  = 34;
    localparam int OUT_W  = 28;
    localparam int PROD_W = IN_W + W_W;

    // Limits expressed at the one-bit-wider width used for the bias sum
    localparam logic signed [ACC_W:0] SAT_MAX = 35'sd134217727;
    localparam logic signed [ACC_W:0] SAT_MIN = -35'sd134217728;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ0 = 3'd1,
        REQ1 = 3'd2,
        REQ2 = 3'd3,
        REQ3 = 3'd4,
        CALC = 3'd5,
        OUT  = 3'd6
    } state_t;

endpackage

// File: rtl/rede_float_mac.sv
// Multiply-accumulate over four weighted samples, followed by a
// floor-shift, bias add, saturation and optional ReLU into a result register.
module rede_float_mac
    import rede_float_pkg::*;
#(
    parameter int                       FRAC = 8,
    parameter logic signed [OUT_W-1:0]  BIAS = '0,
    parameter bit                       RELU = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic                     add,
    input  logic                     capture,
    input  logic signed [W_W-1:0]    weight,
    input  logic signed [IN_W-1:0]   sample,
    output logic signed [OUT_W-1:0]  result
);

    logic signed [PROD_W-1:0] product;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [ACC_W:0]    biased;
    logic signed [OUT_W-1:0]  post;

    assign product = sample * weight;
    assign shifted = acc >>> FRAC;
    assign biased  = (ACC_W + 1)'(shifted) + (ACC_W + 1)'(BIAS);

    always_comb begin
        if (biased > SAT_MAX) begin
            post = OUT_W'(SAT_MAX);
        end else if (biased < SAT_MIN) begin
            post = OUT_W'(SAT_MIN);
        end else begin
            post = biased[OUT_W-1:0];
        end
        if (RELU && (post < 0)) begin
            post = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            result <= '0;
        end else begin
            if (load) begin
                acc <= ACC_W'(product);
            end else if (add) begin
                acc <= acc + ACC_W'(product);
            end
            if (capture) begin
                result <= post;
            end
        end
    end

endmodule

// File: rtl/rede_float_core.sv
// Neuron core: requests four samples in turn, accumulates the weighted sum
// and strobes the post-processed result out once every six cycles.
//
// state | meaning
// IDLE  | one cycle after reset release
// REQ0-3| req_in one-hot for port k, sample taken on the closing edge
// CALC  | accumulator complete, result register loads on the closing edge
// OUT   | out_en strobe, io_out valid
module rede_float_core
    import rede_float_pkg::*;
#(
    parameter logic signed [W_W-1:0]   W0   = '0,
    parameter logic signed [W_W-1:0]   W1   = '0,
    parameter logic signed [W_W-1:0]   W2   = '0,
    parameter logic signed [W_W-1:0]   W3   = '0,
    parameter logic signed [OUT_W-1:0] BIAS = '0,
    parameter bit                      RELU = 1'b1,
    parameter int                      FRAC = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [IN_W-1:0]   io_in,
    output logic signed [OUT_W-1:0]  io_out,
    output logic [3:0]               req_in,
    output logic [3:0]               out_en
);

    state_t              state;
    state_t              state_next;
    logic [3:0]          req_next;
    logic [3:0]          out_en_next;
    logic                load;
    logic                add;
    logic                capture;
    logic signed [W_W-1:0] weight;

    always_comb begin
        state_next  = IDLE;
        req_next    = 4'b0000;
        out_en_next = 4'b0000;
        load        = 1'b0;
        add         = 1'b0;
        capture     = 1'b0;
        weight      = '0;
        case (state)
            IDLE: state_next = REQ0;
            REQ0: begin state_next = REQ1; load = 1'b1; weight = W0; end
            REQ1: begin state_next = REQ2; add  = 1'b1; weight = W1; end
            REQ2: begin state_next = REQ3; add  = 1'b1; weight = W2; end
            REQ3: begin state_next = CALC; add  = 1'b1; weight = W3; end
            CALC: begin state_next = OUT;  capture = 1'b1; end
            OUT:  state_next = REQ0;
            default: state_next = IDLE;
        endcase
        // Strobes are decoded from the next state so they leave flops directly
        case (state_next)
            REQ0: req_next    = 4'b0001;
            REQ1: req_next    = 4'b0010;
            REQ2: req_next    = 4'b0100;
            REQ3: req_next    = 4'b1000;
            OUT:  out_en_next = 4'b0001;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            req_in <= 4'b0000;
            out_en <= 4'b0000;
        end else begin
            state  <= state_next;
            req_in <= req_next;
            out_en <= out_en_next;
        end
    end

    rede_float_mac #(
        .FRAC (FRAC),
        .BIAS (BIAS),
        .RELU (RELU)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst),
        .load    (load),
        .add     (add),
        .capture (capture),
        .weight  (weight),
        .sample  (io_in),
        .result  (io_out)
    );

endmodule

// File: tb/tb_rede_float_core.sv
// Directed bench: five differently parameterised cores share clock, reset and
// io_in; a table of frames is streamed through them and every output checked.
module tb_rede_float_core;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic signed [18:0] io_in = '0;

    logic signed [27:0] io_nom, io_nrelu, io_satp, io_satn, io_floor;
    logic [3:0]         req_nom, req_nrelu, req_satp, req_satn, req_floor;
    logic [3:0]         oen_nom, oen_nrelu, oen_satp, oen_satn, oen_floor;

    always #5 clk = ~clk;

    rede_float_core #(.W0(256), .W1(-128), .W2(512), .W3(0), .BIAS(0), .RELU(1'b1)) u_nom (
        .clk(clk), .rst(rst), .io_in(io_in), .io_out(io_nom), .req_in(req_nom), .out_en(oen_nom));
    rede_float_core #(.W0(256), .W1(-128), .W2(512), .W3(0), .BIAS(0), .RELU(1'b0)) u_nrelu (
        .clk(clk), .rst(rst), .io_in(io_in), .io_out(io_nrelu), .req_in(req_nrelu), .out_en(oen_nrelu));
    rede_float_core #(.W0(256), .W1(-128), .W2(512), .W3(0), .BIAS(134217700), .RELU(1'b1)) u_satp (
        .clk(clk), .rst(rst), .io_in(io_in), .io_out(io_satp), .req_in(req_satp), .out_en(oen_satp));
    rede_float_core #(.W0(0), .W1(0), .W2(0), .W3(0), .BIAS(-134217728), .RELU(1'b0)) u_satn (
        .clk(clk), .rst(rst), .io_in(io_in), .io_out(io_satn), .req_in(req_satn), .out_en(oen_satn));
    rede_float_core #(.W0(1), .W1(0), .W2(0), .W3(0), .BIAS(0), .RELU(1'b0)) u_floor (
        .clk(clk), .rst(rst), .io_in(io_in), .io_out(io_floor), .req_in(req_floor), .out_en(oen_floor));

    typedef struct {
        int s0, s1, s2, s3;
        int e_nom, e_nrelu, e_satp, e_satn, e_floor;
    } vec_t;

    vec_t vecs[5];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_first_req();
        int cyc = 0;
        while (req_nom !== 4'b0001 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("first_req_latency", cyc, 1);
    endtask

    task automatic run_frame(input vec_t v, input longint prev_nom);
        int s[4];
        s[0] = v.s0; s[1] = v.s1; s[2] = v.s2; s[3] = v.s3;
        for (int k = 0; k < 4; k++) begin
            chk("req_in", req_nom, longint'(1 << k));
            chk("out_en_in_req", oen_nom, 0);
            chk("io_out_hold", io_nom, prev_nom);
            io_in = 19'(s[k]);
            @(negedge clk);
        end
        chk("req_in_calc", req_nom, 0);
        chk("out_en_calc", oen_nom, 0);
        io_in = 19'($urandom);
        @(negedge clk);
        chk("out_en_out", oen_nom, 1);
        chk("req_in_out", req_nom, 0);
        chk("io_out_nom", io_nom, v.e_nom);
        chk("io_out_nrelu", io_nrelu, v.e_nrelu);
        chk("io_out_satp", io_satp, v.e_satp);
        chk("io_out_satn", io_satn, v.e_satn);
        chk("io_out_floor", io_floor, v.e_floor);
        chk("out_en_floor", oen_floor, 1);
        io_in = 19'($urandom);
        @(negedge clk);
    endtask

    initial begin
        longint prev;
        vecs[0] = '{100, 200, 300, 400,           600,     600, 134217727, -134217728,     0};
        vecs[1] = '{100, 1000, 0, 0,                0,    -400, 134217300, -134217728,     0};
        vecs[2] = '{-1, 0, 0, 0,                    0,      -1, 134217699, -134217728,    -1};
        vecs[3] = '{-262144, 262143, -262144, 0,    0, -917504, 133300196, -134217728, -1024};
        vecs[4] = '{255, 0, 0, 0,                 255,     255, 134217727, -134217728,     0};

        repeat (3) @(negedge clk);
        chk("reset_req_in", req_nom, 0);
        chk("reset_out_en", oen_nom, 0);
        chk("reset_io_out", io_nom, 0);
        rst = 1'b1;
        wait_first_req();

        prev = 0;
        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i], prev);
            prev = vecs[i].e_nom;
        end

        // Abort a frame during REQ2; io_out_satp is nonzero beforehand
        chk("pre_abort_req0", req_nom, 1);
        io_in = 19'(100);
        @(negedge clk);
        io_in = 19'(200);
        @(negedge clk);
        chk("pre_abort_req2", req_nom, 4);
        chk("pre_abort_satp", io_satp, 134217727);
        #2 rst = 1'b0;
        #1;
        chk("async_req_in", req_nom, 0);
        chk("async_out_en", oen_nom, 0);
        chk("async_io_out_nom", io_nom, 0);
        chk("async_io_out_satp", io_satp, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_first_req();
        run_frame(vecs[0], 0);
        run_frame(vecs[1], vecs[0].e_nom);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
